host_readout_engine: RTL and testbench

Parametrised successor of the frame readout interface. Reads one frame region out of DDR through a user-port read command/data interface and writes it into the host pipe-out FIFO. Bursts are issued only when the FIFO has room for a whole burst. Adds:
- configurable word width and burst size
- a short final burst
- an abort path that drains in-flight read data
- a completion pulse

It sits between the frame-buffer arbiter's read port and the pipe-out FIFO, in the DDR clock domain.

---
 rtl/host_if_pkg.sv | 16 +
 rtl/host_readout_engine.sv | 173 +++++++++++++++++
 tb/tb_host_readout_engine.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_if_pkg.sv
// Shared definitions for the host readout path: FSM state encoding and the
// DDR user-port read opcode driven by the frame-buffer arbiter.
package host_if_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    ISSUE = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  localparam logic [2:0] MEM_CMD_INSTR_RD = 3'b001;

endpackage

// File: rtl/host_readout_engine.sv
// Streams one frame region from DDR into the host pipe-out FIFO, one burst
// outstanding at a time, only when the FIFO can take the whole burst.
module host_readout_engine
  import host_if_pkg::*;
#(
  parameter int DW           = 64,
  parameter int ADDR_W       = 30,
  parameter int COUNT_W      = 24,
  parameter int BURST_WORDS  = 64,
  parameter int OB_DEPTH     = 512,
  parameter int OBC_W        = 10,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_clk,
  input  logic               readout_start,
  input  logic               readout_abort,
  input  logic [ADDR_W-1:0]  readout_addr,
  input  logic [COUNT_W-1:0] readout_count,
  output logic               busy,
  output logic               done,
  output logic               mem_cmd_en,
  output logic [ADDR_W-1:0]  mem_cmd_byte_addr,
  output logic [5:0]         mem_cmd_bl,
  input  logic               mem_cmd_full,
  output logic               mem_rd_en,
  input  logic [DW-1:0]      mem_rd_data,
  input  logic               mem_rd_empty,
  output logic               ob_rst,
  output logic               ob_wr_en,
  output logic [DW-1:0]      ob_din,
  input  logic [OBC_W-1:0]   ob_count
);

  localparam int BPW    = DW / 8;
  localparam int BPW_SH = $clog2(BPW);
  localparam int BL_W   = $clog2(BURST_WORDS) + 1;
  localparam int FC_W   = $clog2(FLUSH_CYCLES + 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [COUNT_W-1:0]  r_rem_words;
  logic [BL_W-1:0]     r_burst_left;
  logic [FC_W-1:0]     r_flush_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ob_rst;
  logic                r_cmd_en;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [5:0]          r_cmd_bl;
  logic                r_ob_wr_en_p1;
  logic [DW-1:0]       r_ob_din_p1;

  logic [COUNT_W-1:0]  w_words_total;
  logic [BL_W-1:0]     w_bw;
  logic                w_room;
  logic                w_pop;
  logic                w_last_pop;

  assign w_words_total = readout_count >> BPW_SH;
  assign w_bw = (r_rem_words < COUNT_W'(BURST_WORDS)) ? BL_W'(r_rem_words)
                                                       : BL_W'(BURST_WORDS);
  assign w_room = (32'(ob_count) + 32'(w_bw)) <= 32'(OB_DEPTH);

  // Pops are gated by burst_left so DATA and DRAIN never over-read a burst.
  assign w_pop = ((r_state == DATA) || (r_state == DRAIN)) && !mem_rd_empty
                 && (r_burst_left != '0);
  assign w_last_pop = w_pop && (r_burst_left == BL_W'(1));

  assign mem_rd_en         = w_pop;
  assign busy              = r_busy;
  assign done              = r_done;
  assign ob_rst            = r_ob_rst;
  assign mem_cmd_en        = r_cmd_en;
  assign mem_cmd_byte_addr = r_cmd_addr;
  assign mem_cmd_bl        = r_cmd_bl;
  assign ob_wr_en          = r_ob_wr_en_p1;
  assign ob_din            = r_ob_din_p1;

  always_ff @(posedge clk or posedge reset_clk) begin
    if (reset_clk) begin
      r_state       <= IDLE;
      r_cur_addr    <= '0;
      r_rem_words   <= '0;
      r_burst_left  <= '0;
      r_flush_cnt   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ob_rst      <= 1'b1;
      r_cmd_en      <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_bl      <= '0;
      r_ob_wr_en_p1 <= 1'b0;
      r_ob_din_p1   <= '0;
    end else begin
      r_cmd_en <= 1'b0;
      r_done   <= 1'b0;
      // Stage p1: the word popped this cycle lands in the FIFO next cycle;
      // words popped on or after an abort are discarded.
      r_ob_wr_en_p1 <= w_pop && (r_state == DATA) && !readout_abort;
      if (w_pop) begin
        r_ob_din_p1  <= mem_rd_data;
        r_burst_left <= r_burst_left - 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (readout_start && !readout_abort) begin
            r_cur_addr  <= readout_addr;
            r_rem_words <= w_words_total;
            r_flush_cnt <= '0;
            r_busy      <= 1'b1;
            r_state     <= (w_words_total == '0) ? DONE : FLUSH;
          end
        end
        FLUSH: begin
          if (readout_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
            r_ob_rst <= 1'b0;
            r_state  <= ISSUE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (readout_abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_ob_rst <= 1'b1;
          end else if (w_room && !mem_cmd_full) begin
            r_cmd_en     <= 1'b1;
            r_cmd_addr   <= r_cur_addr;
            r_cmd_bl     <= 6'(w_bw - 1'b1);
            r_burst_left <= w_bw;
            r_cur_addr   <= r_cur_addr + (ADDR_W'(w_bw) << BPW_SH);
            r_state      <= DATA;
          end
        end
        DATA: begin
          if (w_pop) r_rem_words <= r_rem_words - 1'b1;
          if (readout_abort) begin
            if (w_last_pop) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_ob_rst <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else if (w_last_pop) begin
            r_state <= (r_rem_words == COUNT_W'(1)) ? DONE : ISSUE;
          end
        end
        DONE: begin
          // The pulse is issued on leaving DONE so a late abort can still cancel it.
          r_done   <= !readout_abort;
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_ob_rst <= 1'b1;
        end
        DRAIN: begin
          if (w_last_pop) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_ob_rst <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_readout_engine.sv
// Bench for host_readout_engine: table-driven frames against a latency memory
// model, plus hand sequences for backpressure, abort, cmd_full and reset.
module tb_host_readout_engine;

  localparam int DW = 64, ADDR_W = 30, COUNT_W = 24, BURST_WORDS = 64;
  localparam int OB_DEPTH = 512, OBC_W = 10, FLUSH_CYCLES = 4;
  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               reset_clk;
  logic               readout_start, readout_abort;
  logic [ADDR_W-1:0]  readout_addr;
  logic [COUNT_W-1:0] readout_count;
  logic               busy, done, mem_cmd_en, mem_cmd_full, mem_rd_en, mem_rd_empty;
  logic [ADDR_W-1:0]  mem_cmd_byte_addr;
  logic [5:0]         mem_cmd_bl;
  logic [DW-1:0]      mem_rd_data, ob_din;
  logic               ob_rst, ob_wr_en;
  logic [OBC_W-1:0]   ob_count;

  always #5 clk = ~clk;

  host_readout_engine #(
    .DW(DW), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .BURST_WORDS(BURST_WORDS),
    .OB_DEPTH(OB_DEPTH), .OBC_W(OBC_W), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .reset_clk(reset_clk),
    .readout_start(readout_start), .readout_abort(readout_abort),
    .readout_addr(readout_addr), .readout_count(readout_count),
    .busy(busy), .done(done),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_cmd_bl(mem_cmd_bl), .mem_cmd_full(mem_cmd_full),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty),
    .ob_rst(ob_rst), .ob_wr_en(ob_wr_en), .ob_din(ob_din), .ob_count(ob_count)
  );

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [COUNT_W-1:0] count;
    int                 exp_words;
    int                 exp_cmds;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            rdy;
  } pend_t;

  vec_t              vecs[6];
  int                total = 0, bad = 0;
  logic [DW-1:0]     exp_q[$];
  logic [ADDR_W+5:0] cmd_q[$];
  logic [DW-1:0]     rdq[$];
  pend_t             pend[$];
  int                cyc = 0, pops_applied = 0, n_wr = 0, n_cmd = 0, n_done = 0;

  function automatic logic [DW-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {32'(a) ^ 32'hDEAD_BEEF, 2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory: commands sampled mid-cycle, data streams into the read FIFO LAT cycles later.
  initial begin
    logic p, c;
    logic [ADDR_W-1:0] ca;
    logic [5:0] cbl;
    pend_t pe;
    mem_rd_empty = 1'b1;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      p = mem_rd_en; c = mem_cmd_en; ca = mem_cmd_byte_addr; cbl = mem_cmd_bl;
      @(posedge clk);
      #1;
      cyc++;
      if (p && rdq.size() > 0) begin
        void'(rdq.pop_front());
        pops_applied++;
      end
      if (c)
        for (int k = 0; k <= int'(cbl); k++)
          pend.push_back('{mem_word(ca + ADDR_W'(k * 8)), cyc + LAT});
      if (pend.size() > 0 && pend[0].rdy <= cyc) begin
        pe = pend.pop_front();
        rdq.push_back(pe.d);
      end
      mem_rd_empty = (rdq.size() == 0);
      mem_rd_data  = (rdq.size() > 0) ? rdq[0] : '0;
    end
  end

  // Scoreboard: compare every command and FIFO write against the expected queues.
  initial begin
    logic [ADDR_W+5:0] ec;
    forever begin
      @(negedge clk);
      if (mem_cmd_en) begin
        n_cmd++;
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_extra: actual addr=%0h required=no command", mem_cmd_byte_addr);
        end else begin
          ec = cmd_q.pop_front();
          chk("cmd_addr", 64'(mem_cmd_byte_addr), 64'(ec[ADDR_W+5:6]));
          chk("cmd_bl", 64'(mem_cmd_bl), 64'(ec[5:0]));
        end
      end
      if (ob_wr_en) begin
        n_wr++;
        chk("wr_during_ob_rst", 64'(ob_rst), 64'(0));
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_extra: actual data=%0h required=no write", ob_din);
        end else begin
          chk("ob_din", ob_din, exp_q.pop_front());
        end
      end
      if (done) n_done++;
    end
  end

  task automatic push_frame(input logic [ADDR_W-1:0] a0, input logic [COUNT_W-1:0] cnt,
                            input int max_wr);
    int rem, bw, nw;
    logic [ADDR_W-1:0] a;
    rem = int'(cnt) / 8; a = a0; nw = 0;
    while (rem > 0) begin
      bw = (rem < BURST_WORDS) ? rem : BURST_WORDS;
      cmd_q.push_back({a, 6'(bw - 1)});
      for (int k = 0; k < bw; k++) begin
        if (nw < max_wr) exp_q.push_back(mem_word(a + ADDR_W'(k * 8)));
        nw++;
      end
      a = a + ADDR_W'(bw * 8);
      rem -= bw;
    end
  endtask

  task automatic start(input logic [ADDR_W-1:0] a, input logic [COUNT_W-1:0] c);
    readout_addr = a; readout_count = c; readout_start = 1'b1;
    tick(1);
    readout_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: actual busy=1 after 3000 cycles required=0", name);
    end
    tick(3);
  endtask

  task automatic wait_pops(input int base, input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pops_applied - base >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_pop_timeout: actual pops=%0d required=%0d", name, pops_applied - base, n);
    end
  endtask

  task automatic clear_counts();
    n_wr = 0; n_cmd = 0; n_done = 0;
  endtask

  task automatic run_frame(input vec_t v, input string name);
    clear_counts();
    push_frame(v.addr, v.count, 1 << 30);
    start(v.addr, v.count);
    wait_idle(name);
    chk({name, "_writes"}, 64'(n_wr), 64'(v.exp_words));
    chk({name, "_cmds"}, 64'(n_cmd), 64'(v.exp_cmds));
    chk({name, "_done"}, 64'(n_done), 64'(1));
    chk({name, "_left_data"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_left_cmds"}, 64'(cmd_q.size()), 64'(0));
    chk({name, "_ob_rst_idle"}, 64'(ob_rst), 64'(1));
  endtask

  initial begin
    int p0;
    reset_clk = 1'b1; readout_start = 1'b0; readout_abort = 1'b0;
    readout_addr = '0; readout_count = '0; mem_cmd_full = 1'b0; ob_count = '0;

    vecs[0] = '{30'h0000_1000, 24'd1024, 128, 2};
    vecs[1] = '{30'h0000_2000, 24'd840, 105, 2};
    vecs[2] = '{30'h0000_3000, 24'd517, 64, 1};
    vecs[3] = '{30'h0000_4000, 24'd8, 1, 1};
    vecs[4] = '{30'h3FFF_FE00, 24'd1024, 128, 2};
    vecs[5] = '{30'h0000_5000, 24'd7, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cmd_en", 64'(mem_cmd_en), 64'(0));
    chk("rst_ob_wr_en", 64'(ob_wr_en), 64'(0));
    chk("rst_ob_rst", 64'(ob_rst), 64'(1));
    @(posedge clk);
    #2 reset_clk = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // FIFO-room backpressure, including the 449 vs 448 boundary.
    clear_counts();
    ob_count = 10'd460;
    push_frame(30'h5000, 24'd512, 1 << 30);
    start(30'h5000, 24'd512);
    tick(20);
    chk("bp460_no_cmd", 64'(n_cmd), 64'(0));
    ob_count = 10'd449;
    tick(10);
    chk("bp449_no_cmd", 64'(n_cmd), 64'(0));
    ob_count = 10'd448;
    @(posedge clk);
    @(negedge clk);
    chk("bp448_cmd_next", 64'(mem_cmd_en), 64'(1));
    tick(1);
    ob_count = '0;
    wait_idle("bp");
    chk("bp_writes", 64'(n_wr), 64'(64));
    chk("bp_cmds", 64'(n_cmd), 64'(1));
    chk("bp_done", 64'(n_done), 64'(1));

    // Abort after 10 words of a 64-word burst.
    clear_counts();
    p0 = pops_applied;
    push_frame(30'h6000, 24'd1024, 10);
    start(30'h6000, 24'd1024);
    wait_pops(p0, 10, "abort");
    readout_abort = 1'b1;
    tick(1);
    readout_abort = 1'b0;
    wait_idle("abort");
    chk("abort_writes", 64'(n_wr), 64'(10));
    chk("abort_pops", 64'(pops_applied - p0), 64'(64));
    chk("abort_no_done", 64'(n_done), 64'(0));
    chk("abort_cmds", 64'(n_cmd), 64'(1));
    chk("abort_rd_fifo_empty", 64'(rdq.size() + pend.size()), 64'(0));
    cmd_q.delete();
    exp_q.delete();
    run_frame('{30'h8000, 24'd512, 64, 1}, "after_abort");

    // Command queue full for ~20 cycles, plus a stray start while busy.
    clear_counts();
    mem_cmd_full = 1'b1;
    push_frame(30'h7000, 24'd512, 1 << 30);
    start(30'h7000, 24'd512);
    tick(8);
    start(30'h9000, 24'd1024);
    tick(11);
    chk("full_no_cmd", 64'(n_cmd), 64'(0));
    mem_cmd_full = 1'b0;
    wait_idle("full");
    chk("full_cmds", 64'(n_cmd), 64'(1));
    chk("full_writes", 64'(n_wr), 64'(64));
    chk("full_done", 64'(n_done), 64'(1));
    chk("full_left_cmds", 64'(cmd_q.size()), 64'(0));

    // Asynchronous reset in the middle of a data burst.
    clear_counts();
    p0 = pops_applied;
    push_frame(30'h1000, 24'd1024, 1 << 30);
    start(30'h1000, 24'd1024);
    wait_pops(p0, 20, "rst");
    reset_clk = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ob_rst", 64'(ob_rst), 64'(1));
    chk("midrst_ob_wr_en", 64'(ob_wr_en), 64'(0));
    chk("midrst_rd_en", 64'(mem_rd_en), 64'(0));
    chk("midrst_ob_din", 64'(ob_din), 64'(0));
    tick(2);
    exp_q.delete(); cmd_q.delete(); rdq.delete(); pend.delete();
    reset_clk = 1'b0;
    tick(2);
    run_frame('{30'h0000_5000, 24'd7, 0, 0}, "post_rst_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
